// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM read port among NREQ sprite controllers and tags returned words with the owner index.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; the default build uses fixed priority (index 0 highest).
module sprite_rom_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 15,
  parameter int DW      = 8,
  parameter int ROM_LAT = 2,
  parameter int IDW     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    grant,
  output logic [AW-1:0]      rom_addr,
  output logic               rom_rden,
  input  logic [DW-1:0]      rom_q,
  output logic               rd_valid,
  output logic [IDW-1:0]     rd_id,
  output logic [DW-1:0]      rd_data,
  output logic [15:0]        miss_cnt
);

  localparam int NPAD = 1 << IDW;

  logic [NPAD-1:0] req_pad;
  logic [IDW-1:0]  win_idx;
  logic            win_any;
  logic [AW-1:0]   win_addr;
  logic            miss;

  assign req_pad = NPAD'(req);

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] ptr;
  logic [IDW:0]   cand;

  // Search starts at the pointer and wraps at NREQ, not at 2^IDW.
  always_comb begin
    win_idx = '0;
    win_any = 1'b0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!win_any && req_pad[cand[IDW-1:0]]) begin
        win_any = 1'b1;
        win_idx = cand[IDW-1:0];
      end
    end
  end

  // A grant in the frame_start cycle still uses the old pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (frame_start) begin
      ptr <= '0;
    end else if (win_any) begin
      ptr <= (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + IDW'(1);
    end
  end
`else
  always_comb begin
    win_idx = '0;
    win_any = |req;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (req[k]) win_idx = IDW'(k);
    end
  end
`endif

  always_comb begin
    grant = '0;
    if (win_any) grant = NREQ'(1) << win_idx;
  end

  always_comb begin
    win_addr = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win_idx == IDW'(k)) win_addr = req_addr[k*AW +: AW];
    end
  end

  assign miss = |(req & ~grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
      rom_rden <= 1'b0;
    end else begin
      rom_rden <= win_any;
      if (win_any) rom_addr <= win_addr;
    end
  end

  // Tag stage ROM_LAT lines up with rom_q for the same read.
  logic [ROM_LAT:0] tag_vld;
  logic [IDW-1:0]   tag_id [ROM_LAT+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      for (int k = 0; k <= ROM_LAT; k++) tag_id[k] <= '0;
    end else begin
      tag_vld   <= {tag_vld[ROM_LAT-1:0], win_any};
      tag_id[0] <= win_idx;
      for (int k = 1; k <= ROM_LAT; k++) tag_id[k] <= tag_id[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_id    <= '0;
      rd_data  <= '0;
    end else if (tag_vld[ROM_LAT]) begin
      rd_valid <= 1'b1;
      rd_id    <= tag_id[ROM_LAT];
      rd_data  <= rom_q;
    end else begin
      rd_valid <= 1'b0;
    end
  end

  // A miss in the frame_start cycle counts toward the new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_cnt <= '0;
    end else if (frame_start) begin
      miss_cnt <= miss ? 16'd1 : 16'd0;
    end else if (miss && miss_cnt != 16'hFFFF) begin
      miss_cnt <= miss_cnt + 16'd1;
    end
  end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares one synchronous sprite ROM read port among up to NREQ sprite controllers (pause banner, player, invaders, shots) that would otherwise each need a private ROM. Each cycle it grants at most one requester, drives the ROM address, and returns the ROM word tagged with the requester index after a fixed pipeline delay. It sits between the sprite controllers and the shared ROM, ahead of the pixel mixer.

## Interface
- NREQ, 4: number of requesters, 2..8
- AW, 15: ROM address width
- DW, 8: ROM data width
- ROM_LAT, 2: ROM read latency in cycles, from address/rden registered to q valid, 1..3
- IDW, 3: requester index width, must satisfy 2^IDW >= NREQ

Ports:
- clk  in  1  pixel clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at frame start (line 0, pixel 0)
- req  in  NREQ  per-requester read request; held until granted
- req_addr  in  NREQ*AW  requester i address in bits [i*AW +: AW]; stable while req[i] is high
- grant  out  NREQ  one-hot combinational grant; requester advances its address on req & grant
- rom_addr  out  AW  registered ROM address
- rom_rden  out  1  registered ROM read enable
- rom_q  in  DW  ROM data, valid ROM_LAT cycles after rom_rden
- rd_valid  out  1  returned word valid
- rd_id  out  IDW  index of the requester owning rd_data
- rd_data  out  DW  returned ROM word
- miss_cnt  out  16  saturating count of cycles in the current frame with at least one ungranted request

## Operation
- Grant: if req is nonzero, exactly one grant bit is high, chosen by the arbitration policy (see Configuration). If req is zero, grant is zero. grant never asserts a bit whose req is low.
- Issue: on a cycle with a grant, the next edge registers rom_addr <= req_addr of the winner, rom_rden <= 1, and pushes the winner's index into a ROM_LAT+1 deep tag shift register. With no grant, rom_rden <= 0 and rom_addr holds its value.
- Return: when the tag-pipe valid bit reaches the end, rd_valid <= 1, rd_id <= tag, rd_data <= rom_q on the same edge. Otherwise rd_valid <= 0 and rd_id and rd_data hold.
- miss_cnt: increments by 1 on every cycle where req & ~grant is nonzero, and saturates at 16'hFFFF. frame_start clears it to 0. If frame_start and a miss occur in the same cycle, the result is 1.
- frame_start does not flush in-flight reads.
- Reset: grant follows req combinationally even during reset, but nothing is issued. rom_addr=0, rom_rden=0, rd_valid=0, rd_id=0, rd_data=0, miss_cnt=0, the round-robin pointer is 0, and all tag-pipe valid bits are cleared. In-flight reads are dropped, so no rd_valid appears for them after reset. Reset wins over all other inputs.

## Timing
- Request granted in cycle t: rom_rden and rom_addr are high/valid at t+1, rom_q is valid at t+1+ROM_LAT, and rd_valid/rd_data appear at t+2+ROM_LAT. Total latency is ROM_LAT+2 cycles, which is 4 at default.
- Throughput: one read per cycle, sustained. Back-to-back grants to different requesters return in grant order, with no reordering.
- A single requester held high continuously is granted every cycle under both policies.

## Configuration
- ARB_ROUND_ROBIN_EN defined: round-robin arbitration. The pointer p starts at 0. The winner is the first requester with req high in the order p, p+1, …, NREQ-1, 0, …. After a grant to index k, p <= (k+1) mod NREQ. p does not change on cycles with no grant. frame_start resets p to 0; if a grant occurs in the same cycle, the grant uses the old p and p then becomes 0.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, where index 0 is highest and higher indices are lower. No pointer state exists. Starvation of lower indices is permitted and is reflected in miss_cnt.

## Test plan
- Reset then idle: rst high for 3 cycles with req=4'b1111 → rom_rden=0, rd_valid=0, and miss_cnt=0 throughout. After release, the first rd_valid comes ROM_LAT+2 cycles after the first grant.
- Single requester: req=4'b0100 with addr 0x0123, and the ROM model returns the address's low byte → grant=4'b0100 every cycle, rom_addr=0x0123 at t+1, rd_valid=1, rd_id=2, rd_data=0x23 at t+4.
- All requesting with round-robin enabled: req=4'b1111 for 8 cycles → grants 0,1,2,3,0,1,2,3, rd_id follows the same sequence 4 cycles later, and miss_cnt=8.
- All requesting with fixed priority: req=4'b1011 for 5 cycles → grant=4'b0001 every cycle and miss_cnt=5.
- frame_start collision: frame_start in the same cycle as a miss, with miss_cnt at 0x0040 → miss_cnt=1 next cycle. With round-robin and p=2, a grant to 2 occurs and then p=0.
- Reset mid-flight: grants at t and t+1, then rst at t+2 → no rd_valid at t+4 or t+5. Saturation check: force the count to 0xFFFE, miss for 3 cycles → it holds at 0xFFFF.
